// File: rtl/dead_time_mc.sv
// dead_time_mc: multi-channel complementary dead-time generator.
// Each channel turns one raw PWM leg into an A/B gate pair with independent
// A-rise and B-rise dead times, output polarity, enable and a sticky
// short-pulse flag. Channels share no state.
// Optional feature: define DT_SHADOW_EN to freeze the dead-time values for
// the duration of each dead-time interval (shadow registers loaded only in
// OFF/AON/BON). Without it the live dtime inputs are compared every cycle.
module dead_time_mc #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DT_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      pwm,
  input  logic [N_CH*DT_W-1:0] dtime_A,
  input  logic [N_CH*DT_W-1:0] dtime_B,
  input  logic [N_CH-1:0]      logic_A,
  input  logic [N_CH-1:0]      logic_B,
  input  logic [N_CH-1:0]      pwm_onoff,
  input  logic [N_CH-1:0]      short_clr,
  output logic [N_CH-1:0]      pwmout_A,
  output logic [N_CH-1:0]      pwmout_B,
  output logic [N_CH-1:0]      dt_active,
  output logic [N_CH-1:0]      short_pulse
);

  typedef enum logic [2:0] {
    OFF = 3'd0,
    DTA = 3'd1,
    AON = 3'd2,
    DTB = 3'd3,
    BON = 3'd4
  } state_t;

  localparam logic [DT_W-1:0] CNT_MAX  = {DT_W{1'b1}};
  localparam logic [DT_W-1:0] CNT_ONE  = DT_W'(1);
  localparam logic [DT_W-1:0] CNT_ZERO = DT_W'(0);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t          state;
    state_t          state_nx;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_nx;
    logic [DT_W-1:0] dt_a;
    logic [DT_W-1:0] dt_b;
    logic [DT_W-1:0] live_a;
    logic [DT_W-1:0] live_b;
    logic            short_q;
    logic            short_nx;
    logic            short_set;
    logic            dt_q;
    logic            dt_nx;
    logic            go_a;
    logic            go_b;
    logic            aux_a;
    logic            aux_b;

    assign live_a = dtime_A[i*DT_W +: DT_W];
    assign live_b = dtime_B[i*DT_W +: DT_W];

`ifdef DT_SHADOW_EN
    logic [DT_W-1:0] shd_a;
    logic [DT_W-1:0] shd_b;
    logic            load;

    // Shadows follow the inputs outside dead time; the value captured on the
    // edge that enters a dead-time interval stays frozen until it ends.
    assign load = (state == OFF) || (state == AON) || (state == BON);

    // Shadow dead-time registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        shd_a <= CNT_ZERO;
        shd_b <= CNT_ZERO;
      end else if (load) begin
        shd_a <= live_a;
        shd_b <= live_b;
      end
    end

    assign dt_a = load ? live_a : shd_a;
    assign dt_b = load ? live_b : shd_b;
`else
    assign dt_a = live_a;
    assign dt_b = live_b;
`endif

    // State, counter, dead-time indicator and sticky short-pulse flag
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= OFF;
        cnt     <= CNT_ZERO;
        short_q <= 1'b0;
        dt_q    <= 1'b0;
      end else begin
        state   <= state_nx;
        cnt     <= cnt_nx;
        short_q <= short_nx;
        dt_q    <= dt_nx;
      end
    end

    // Next-state: leg requests, dead-time counting, short-pulse detection
    always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      short_set = 1'b0;
      go_a      = 1'b0;
      go_b      = 1'b0;

      if (!pwm_onoff[i]) begin
        state_nx = OFF;
        cnt_nx   = CNT_ZERO;
      end else begin
        unique case (state)
          OFF: begin
            if (pwm[i]) go_a = 1'b1;
            else        go_b = 1'b1;
          end
          BON: begin
            if (pwm[i]) go_a = 1'b1;
          end
          AON: begin
            if (!pwm[i]) go_b = 1'b1;
          end
          DTA: begin
            if (!pwm[i]) begin
              go_b      = 1'b1;
              short_set = 1'b1;
            end else if (cnt >= dt_a) begin
              state_nx = AON;
            end else if (cnt != CNT_MAX) begin
              cnt_nx = cnt + CNT_ONE;
            end
          end
          DTB: begin
            if (pwm[i]) begin
              go_a      = 1'b1;
              short_set = 1'b1;
            end else if (cnt >= dt_b) begin
              state_nx = BON;
            end else if (cnt != CNT_MAX) begin
              cnt_nx = cnt + CNT_ONE;
            end
          end
          default: begin
            state_nx = OFF;
            cnt_nx   = CNT_ZERO;
          end
        endcase

        // A zero dead time skips the interval entirely
        if (go_a) begin
          if (dt_a == CNT_ZERO) begin
            state_nx = AON;
          end else begin
            state_nx = DTA;
            cnt_nx   = CNT_ONE;
          end
        end else if (go_b) begin
          if (dt_b == CNT_ZERO) begin
            state_nx = BON;
          end else begin
            state_nx = DTB;
            cnt_nx   = CNT_ONE;
          end
        end
      end

      // A new short event outranks a clear strobe in the same cycle
      if (short_set)         short_nx = 1'b1;
      else if (short_clr[i]) short_nx = 1'b0;
      else                   short_nx = short_q;

      dt_nx = (state_nx == DTA) || (state_nx == DTB);
    end

    assign aux_a = (state == AON);
    assign aux_b = (state == BON);

    // Gate outputs: polarity applied, then forced low when disabled
    assign pwmout_A[i]    = (aux_a ^ logic_A[i]) & pwm_onoff[i];
    assign pwmout_B[i]    = (aux_b ^ logic_B[i]) & pwm_onoff[i];
    assign dt_active[i]   = dt_q;
    assign short_pulse[i] = short_q;
  end

endmodule
